// File: rtl/panda_risc_v_long_inst_tracker_if.sv
`default_nettype none
// ============================================================================
// Module      : panda_risc_v_long_inst_tracker_if
// Description : Dispatch-side bundle for the long-instruction tracker:
//               hazard checks, allocation handshake, write-back free, status.
// Revision    : 1.0 - initial release
// ============================================================================
interface panda_risc_v_long_inst_tracker_if #(
    parameter int TID_W = 2
);
    logic [4:0]       waw_dpc_check_rd_id;
    logic             rd_waw_dpc;
    logic [4:0]       raw_dpc_check_rs1_id;
    logic             rs1_raw_dpc;
    logic [4:0]       raw_dpc_check_rs2_id;
    logic             rs2_raw_dpc;
    logic [4:0]       s_alloc_rd_id;
    logic             s_alloc_rd_vld;
    logic             s_alloc_valid;
    logic             s_alloc_ready;
    logic [TID_W-1:0] s_alloc_tid;
    logic [TID_W-1:0] s_wb_tid;
    logic             s_wb_valid;
    logic [TID_W:0]   long_inst_cnt;
    logic             long_inst_empty;
    logic             tracker_err;

    // Dispatcher / write-back side
    modport master (
        output waw_dpc_check_rd_id, raw_dpc_check_rs1_id, raw_dpc_check_rs2_id,
        output s_alloc_rd_id, s_alloc_rd_vld, s_alloc_valid, s_wb_tid, s_wb_valid,
        input  rd_waw_dpc, rs1_raw_dpc, rs2_raw_dpc, s_alloc_ready, s_alloc_tid,
        input  long_inst_cnt, long_inst_empty, tracker_err
    );

    // Tracker side
    modport slave (
        input  waw_dpc_check_rd_id, raw_dpc_check_rs1_id, raw_dpc_check_rs2_id,
        input  s_alloc_rd_id, s_alloc_rd_vld, s_alloc_valid, s_wb_tid, s_wb_valid,
        output rd_waw_dpc, rs1_raw_dpc, rs2_raw_dpc, s_alloc_ready, s_alloc_tid,
        output long_inst_cnt, long_inst_empty, tracker_err
    );
endinterface
`default_nettype wire

// File: rtl/panda_risc_v_long_inst_tracker.sv
`default_nettype none
// ============================================================================
// Module      : panda_risc_v_long_inst_tracker
// Description : Tracks in-flight long instructions (ld/st/mul/div) and supplies
//               RAW/WAW hazard flags. Optional macro
//               PANDA_RISC_V_LONG_INST_WB_BYPASS_EN masks entries freed this
//               cycle out of the hazard flags.
// Revision    : 1.0 - initial release
// ============================================================================
module panda_risc_v_long_inst_tracker #(
    parameter int LONG_INST_N = 4,
    parameter int TID_W       = 2
) (
    input  wire logic clk,
    input  wire logic sys_reset,
    panda_risc_v_long_inst_tracker_if.slave trk
);

    logic [LONG_INST_N-1:0] r_vld;
    logic [LONG_INST_N-1:0] r_rd_vld;
    logic [4:0]             r_rd_id [LONG_INST_N];
    logic [TID_W:0]         r_cnt;
    logic                   r_err;

    logic                   w_full;
    logic [TID_W-1:0]       w_alloc_tid;
    logic                   w_alloc_fire;
    logic                   w_wb_hit;
    logic                   w_free_fire;
    logic [LONG_INST_N-1:0] w_free_mask;
    logic [LONG_INST_N-1:0] w_rs1_hit;
    logic [LONG_INST_N-1:0] w_rs2_hit;
    logic [LONG_INST_N-1:0] w_waw_hit;

    assign w_full       = &r_vld;
    assign w_alloc_fire = trk.s_alloc_valid & ~w_full;
    assign w_wb_hit     = r_vld[trk.s_wb_tid];
    assign w_free_fire  = trk.s_wb_valid & w_wb_hit;

    // Lowest free index wins: scan downward so the last match is the lowest.
    always_comb begin
        w_alloc_tid = '0;
        for (int i = LONG_INST_N - 1; i >= 0; i--) begin
            if (!r_vld[i]) begin
                w_alloc_tid = TID_W'(i);
            end
        end
    end

    generate
        for (genvar i = 0; i < LONG_INST_N; i++) begin : g_entry
            logic w_live;
`ifdef PANDA_RISC_V_LONG_INST_WB_BYPASS_EN
            assign w_free_mask[i] = trk.s_wb_valid && (trk.s_wb_tid == TID_W'(i));
`else
            assign w_free_mask[i] = 1'b0;
`endif
            assign w_live       = r_vld[i] & r_rd_vld[i] & ~w_free_mask[i];
            assign w_rs1_hit[i] = w_live && (r_rd_id[i] == trk.raw_dpc_check_rs1_id);
            assign w_rs2_hit[i] = w_live && (r_rd_id[i] == trk.raw_dpc_check_rs2_id);
            assign w_waw_hit[i] = w_live && (r_rd_id[i] == trk.waw_dpc_check_rd_id);
        end
    endgenerate

    // x0 is never a real dependency, even if an entry recorded it.
    assign trk.rs1_raw_dpc = (|w_rs1_hit) && (trk.raw_dpc_check_rs1_id != 5'd0);
    assign trk.rs2_raw_dpc = (|w_rs2_hit) && (trk.raw_dpc_check_rs2_id != 5'd0);
    assign trk.rd_waw_dpc  = (|w_waw_hit) && (trk.waw_dpc_check_rd_id  != 5'd0);

    always_ff @(posedge clk) begin
        if (sys_reset) begin
            r_vld    <= '0;
            r_rd_vld <= '0;
            for (int i = 0; i < LONG_INST_N; i++) begin
                r_rd_id[i] <= 5'd0;
            end
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            // Free and allocate never collide: the target is a currently free slot.
            if (w_free_fire) begin
                r_vld[trk.s_wb_tid] <= 1'b0;
            end
            if (w_alloc_fire) begin
                r_vld[w_alloc_tid]    <= 1'b1;
                r_rd_vld[w_alloc_tid] <= trk.s_alloc_rd_vld;
                r_rd_id[w_alloc_tid]  <= trk.s_alloc_rd_id;
            end
            case ({w_alloc_fire, w_free_fire})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
            if ((trk.s_alloc_valid & w_full) | (trk.s_wb_valid & ~w_wb_hit)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign trk.s_alloc_ready   = ~w_full;
    assign trk.s_alloc_tid     = w_alloc_tid;
    assign trk.long_inst_cnt   = r_cnt;
    assign trk.long_inst_empty = (r_cnt == '0);
    assign trk.tracker_err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_panda_risc_v_long_inst_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_panda_risc_v_long_inst_tracker
// Description : Self-checking bench: directed scenarios plus random traffic
//               compared every cycle against a behavioural tracker model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_panda_risc_v_long_inst_tracker;
    localparam int N     = 4;
    localparam int TID_W = 2;

    logic clk = 1'b0;
    logic sys_reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic model_ok = 1'b0;

    panda_risc_v_long_inst_tracker_if #(.TID_W(TID_W)) bus ();

    panda_risc_v_long_inst_tracker #(.LONG_INST_N(N), .TID_W(TID_W)) dut (
        .clk       (clk),
        .sys_reset (sys_reset),
        .trk       (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: a set of in-flight slots, each with an optional rd.
    logic [N-1:0] m_vld;
    logic [N-1:0] m_rdv;
    logic [4:0]   m_rd [N];
    logic         m_err;

    function automatic int lowest_free();
        for (int i = 0; i < N; i++) if (!m_vld[i]) return i;
        return -1;
    endfunction

    function automatic logic dep(input logic [4:0] id);
        logic hit = 1'b0;
        if (id == 5'd0) return 1'b0;
        for (int i = 0; i < N; i++) begin
            logic freeing = 1'b0;
`ifdef PANDA_RISC_V_LONG_INST_WB_BYPASS_EN
            freeing = bus.s_wb_valid && (int'(bus.s_wb_tid) == i);
`endif
            if (m_vld[i] && m_rdv[i] && m_rd[i] == id && !freeing) hit = 1'b1;
        end
        return hit;
    endfunction

    always @(posedge clk) begin
        if (sys_reset) begin
            model_ok <= 1'b1;
            m_vld    <= '0;
            m_rdv    <= '0;
            m_err    <= 1'b0;
            for (int i = 0; i < N; i++) m_rd[i] <= 5'd0;
        end else begin
            int t;
            t = lowest_free();
            if (bus.s_wb_valid) begin
                if (m_vld[bus.s_wb_tid]) m_vld[bus.s_wb_tid] <= 1'b0;
                else m_err <= 1'b1;
            end
            if (bus.s_alloc_valid) begin
                if (t < 0) m_err <= 1'b1;
                else begin
                    m_vld[t] <= 1'b1;
                    m_rdv[t] <= bus.s_alloc_rd_vld;
                    m_rd[t]  <= bus.s_alloc_rd_id;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (model_ok) begin
            int t;
            t = lowest_free();
            chk("m_cnt",   32'(bus.long_inst_cnt), 32'($countones(m_vld)));
            chk("m_empty", 32'(bus.long_inst_empty), 32'(m_vld == '0));
            chk("m_ready", 32'(bus.s_alloc_ready), 32'(t >= 0));
            if (t >= 0) chk("m_tid", 32'(bus.s_alloc_tid), 32'(t));
            chk("m_err",   32'(bus.tracker_err), 32'(m_err));
            chk("m_rs1",   32'(bus.rs1_raw_dpc), 32'(dep(bus.raw_dpc_check_rs1_id)));
            chk("m_rs2",   32'(bus.rs2_raw_dpc), 32'(dep(bus.raw_dpc_check_rs2_id)));
            chk("m_waw",   32'(bus.rd_waw_dpc),  32'(dep(bus.waw_dpc_check_rd_id)));
        end
    end

    task automatic idle();
        sys_reset         = 1'b0;
        bus.s_alloc_valid = 1'b0;
        bus.s_wb_valid    = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic alloc(input logic [4:0] rd, input logic rdv);
        bus.s_alloc_valid  = 1'b1;
        bus.s_alloc_rd_id  = rd;
        bus.s_alloc_rd_vld = rdv;
    endtask

    task automatic free(input logic [TID_W-1:0] tid);
        bus.s_wb_valid = 1'b1;
        bus.s_wb_tid   = tid;
    endtask

    task automatic set_checks(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        bus.raw_dpc_check_rs1_id = rs1;
        bus.raw_dpc_check_rs2_id = rs2;
        bus.waw_dpc_check_rd_id  = rd;
    endtask

    task automatic do_reset();
        idle();
        sys_reset = 1'b1;
        cycle();
        idle();
    endtask

    initial begin
        idle();
        sys_reset = 1'b1;
        bus.s_alloc_rd_id  = 5'd0;
        bus.s_alloc_rd_vld = 1'b0;
        bus.s_wb_tid       = '0;
        set_checks(5'd5, 5'd5, 5'd5);
        cycle();
        idle();
        sample();
        chk("rst_cnt",   32'(bus.long_inst_cnt), 0);
        chk("rst_empty", 32'(bus.long_inst_empty), 1);
        chk("rst_ready", 32'(bus.s_alloc_ready), 1);
        chk("rst_tid",   32'(bus.s_alloc_tid), 0);
        chk("rst_err",   32'(bus.tracker_err), 0);
        chk("rst_rs1",   32'(bus.rs1_raw_dpc), 0);

        // rd=5 at tid 0 becomes visible next cycle
        alloc(5'd5, 1'b1);
        cycle();
        idle();
        sample();
        chk("a5_rs1", 32'(bus.rs1_raw_dpc), 1);
        chk("a5_waw", 32'(bus.rd_waw_dpc), 1);
        chk("a5_cnt", 32'(bus.long_inst_cnt), 1);
        chk("a5_tid", 32'(bus.s_alloc_tid), 1);

        // x0 and non-writing store never flag
        do_reset();
        alloc(5'd0, 1'b1); cycle();
        alloc(5'd7, 1'b0); cycle();
        idle();
        set_checks(5'd0, 5'd7, 5'd7);
        sample();
        chk("x0_rs1", 32'(bus.rs1_raw_dpc), 0);
        chk("st_rs2", 32'(bus.rs2_raw_dpc), 0);
        chk("st_waw", 32'(bus.rd_waw_dpc), 0);
        chk("x0_cnt", 32'(bus.long_inst_cnt), 2);

        // fill, then overflow request
        alloc(5'd9, 1'b1); cycle();
        alloc(5'd3, 1'b1); cycle();
        idle();
        sample();
        chk("full_ready", 32'(bus.s_alloc_ready), 0);
        chk("full_cnt",   32'(bus.long_inst_cnt), 4);
        alloc(5'd20, 1'b1); cycle();
        idle();
        sample();
        chk("ovf_err", 32'(bus.tracker_err), 1);
        chk("ovf_cnt", 32'(bus.long_inst_cnt), 4);
        cycle();
        sample();
        chk("ovf_sticky", 32'(bus.tracker_err), 1);

        // free while full: allocation in same cycle is refused
        free(2'd2); alloc(5'd11, 1'b1); cycle();
        idle();
        sample();
        chk("fa_ready", 32'(bus.s_alloc_ready), 1);
        chk("fa_tid",   32'(bus.s_alloc_tid), 2);
        chk("fa_cnt",   32'(bus.long_inst_cnt), 3);
        free(2'd0); alloc(5'd12, 1'b1); cycle();
        idle();
        set_checks(5'd12, 5'd11, 5'd9);
        sample();
        chk("fa2_cnt", 32'(bus.long_inst_cnt), 3);
        chk("fa2_tid", 32'(bus.s_alloc_tid), 0);
        chk("fa2_rs1", 32'(bus.rs1_raw_dpc), 1);
        chk("fa2_rs2", 32'(bus.rs2_raw_dpc), 0);
        chk("fa2_waw", 32'(bus.rd_waw_dpc), 0);

        // write-back bypass on rs2
        do_reset();
        alloc(5'd9, 1'b1); cycle();
        idle();
        set_checks(5'd1, 5'd9, 5'd1);
        free(2'd0);
        sample();
`ifdef PANDA_RISC_V_LONG_INST_WB_BYPASS_EN
        chk("byp_rs2", 32'(bus.rs2_raw_dpc), 0);
`else
        chk("byp_rs2", 32'(bus.rs2_raw_dpc), 1);
`endif
        cycle();
        idle();
        sample();
        chk("byp_rs2_next", 32'(bus.rs2_raw_dpc), 0);
        chk("byp_err",      32'(bus.tracker_err), 0);

        // free of an invalid entry
        free(2'd3); cycle();
        idle();
        sample();
        chk("inv_err", 32'(bus.tracker_err), 1);
        chk("inv_cnt", 32'(bus.long_inst_cnt), 0);

        // random traffic with occasional mid-run reset
        for (int k = 0; k < 3000; k++) begin
            sys_reset          = ($urandom_range(0, 199) == 0);
            bus.s_alloc_valid  = ($urandom_range(0, 1) == 1);
            bus.s_alloc_rd_id  = 5'($urandom_range(0, 7));
            bus.s_alloc_rd_vld = ($urandom_range(0, 3) != 0);
            bus.s_wb_valid     = ($urandom_range(0, 9) < 4);
            bus.s_wb_tid       = TID_W'($urandom_range(0, N - 1));
            set_checks(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)));
            cycle();
        end

        // reset with requests pending: they are ignored
        alloc(5'd4, 1'b1);
        free(2'd1);
        sys_reset = 1'b1;
        cycle();
        idle();
        set_checks(5'd4, 5'd4, 5'd4);
        sample();
        chk("end_cnt",   32'(bus.long_inst_cnt), 0);
        chk("end_empty", 32'(bus.long_inst_empty), 1);
        chk("end_err",   32'(bus.tracker_err), 0);
        chk("end_tid",   32'(bus.s_alloc_tid), 0);
        chk("end_rs1",   32'(bus.rs1_raw_dpc), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
